// File: rtl/mux_tdm4_pkg.sv
// -----------------------------------------------------------------------------
// mux_tdm4_pkg
// Shared constants and types for the four-channel TDM multiplexer.
//   NCH   : number of input channels
//   SELW  : width of a channel index / output select
//   occ_t : output-register occupancy (EMPTY, FULL)
// -----------------------------------------------------------------------------
package mux_tdm4_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } occ_t;

endpackage : mux_tdm4_pkg

// File: rtl/mux_tdm4_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Purely combinational 4-way rotating-priority picker. Searches the request
// vector starting at the pointer and wrapping modulo 4; the first requester
// found wins.
// Ports:
//   req  [3:0] in  : per-channel request
//   ptr  [1:0] in  : channel with highest priority this cycle
//   gnt  [3:0] out : one-hot grant (all zero when nothing requests)
//   idx  [1:0] out : index of the granted channel (0 when no grant)
//   any        out : a grant was made
// -----------------------------------------------------------------------------
module rr_pick4
  import mux_tdm4_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [SELW-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise unassigned paths infer latches.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NCH; i++) begin
      // 2-bit addition wraps naturally, giving the mod-4 search order.
      cand = ptr + SELW'(i);
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule : rr_pick4

// File: rtl/mux_tdm4.sv
// -----------------------------------------------------------------------------
// mux_tdm4
// Four-channel time-division multiplexer. Accepts words from four producers
// over valid/ready, arbitrates round-robin and emits one registered word per
// cycle tagged with its channel index (drives the demux select downstream).
//
// Build option:
//   MUX_TDM4_FIXED_PRI_EN : when defined, the rotating pointer is removed and
//                           channel 0 always has highest priority (0,1,2,3).
//
// Ports:
//   clk              in  : clock, rising edge
//   rst_n            in  : asynchronous active-low reset
//   in_data  [4W-1:0] in : channel k word at [k*W +: W]
//   in_valid [3:0]   in  : per-channel word available
//   in_ready [3:0]   out : per-channel word accepted this cycle (<= 1 bit set)
//   out_data [W-1:0] out : registered output word
//   out_sel  [1:0]   out : channel index of out_data
//   out_valid        out : output register holds a word
//   out_ready        in  : downstream accepts the output word
// -----------------------------------------------------------------------------
module mux_tdm4
  import mux_tdm4_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  occ_t            state;
  logic            load_en;
  logic            xfer;
  logic [NCH-1:0]  pick_gnt;
  logic [SELW-1:0] pick_idx;
  logic            pick_any;
  logic [SELW-1:0] pick_ptr;

  assign out_valid = (state == FULL);

  // The register can take a new word when empty, or when its current word
  // leaves on this same edge (back-to-back drain and load).
  assign load_en = (state == EMPTY) | (out_valid & out_ready);
  assign xfer    = load_en & pick_any;

  // rst_n gating keeps every ready low for the whole reset window, even if
  // producers are already presenting data.
  assign in_ready = (load_en && rst_n) ? pick_gnt : '0;

  rr_pick4 u_pick (
    .req (in_valid),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef MUX_TDM4_FIXED_PRI_EN
  assign pick_ptr = '0;
`else
  logic [SELW-1:0] ptr;

  // Pointer moves past the winner only on an actual transfer, so a channel
  // that was just served drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= pick_idx + SELW'(1);
    end
  end

  assign pick_ptr = ptr;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  // NOTE: the data register is reset too (not just the occupancy flag) so the
  // output line shows a defined 0 after reset rather than stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
    end else if (xfer) begin
      state    <= FULL;
      out_data <= in_data[pick_idx*W +: W];
      out_sel  <= pick_idx;
    end else if (out_valid && out_ready) begin
      // Drained with nothing to replace it; data/select hold last values.
      state <= EMPTY;
    end
  end

endmodule : mux_tdm4

// File: tb/tb_mux_tdm4.sv
// -----------------------------------------------------------------------------
// tb_mux_tdm4
// Self-checking bench for mux_tdm4: a table of directed vectors, hand-written
// multi-cycle sequences (backpressure, pointer wrap, mid-operation reset) and a
// randomized phase compared every cycle against a behavioural model.
// Honours MUX_TDM4_FIXED_PRI_EN for the expected grant order.
// -----------------------------------------------------------------------------
module tb_mux_tdm4;

  localparam int W = 4;
`ifdef MUX_TDM4_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [3:0]     in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  mux_tdm4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One held word (full flag, data, channel) and the channel with top priority.
  bit           m_full;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  int           m_last;

  // Channel accepted this cycle, or -1 if none.
  function automatic int m_pick();
    if (m_full && !out_ready) return -1;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (m_ptr + i) % 4;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_sel  = 0;
    m_ptr  = 0;
    m_last = -1;
  endtask

  task automatic model_edge();
    int g;
    g = m_pick();
    m_last = g;
    if (g >= 0) begin
      m_data = in_data[g*W +: W];
      m_sel  = g;
      m_full = 1'b1;
      if (!FIXED) m_ptr = (g + 1) % 4;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic compare_model();
    int         g;
    logic [3:0] e;
    g = m_pick();
    e = (g >= 0) ? 4'(1 << g) : 4'd0;
    check("m_in_ready", 32'(in_ready), 32'(e));
    check("m_out_valid", 32'(out_valid), 32'(m_full));
    check("m_out_sel", 32'(out_sel), 32'(m_sel));
    check("m_out_data", 32'(out_data), 32'(m_data));
  endtask

  // Called mid-cycle with inputs already applied; returns 1 time unit after
  // the next rising edge.
  task automatic tick();
    #2;
    compare_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]     valid;
    logic [4*W-1:0] data;
    logic           ordy;
    logic [3:0]     exp_rdy;
    logic [1:0]     exp_sel;
    logic [W-1:0]   exp_data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int ch;

    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    // Four channels carrying 0,1,1,0; round-robin gives 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      ch = FIXED ? 0 : (i % 4);
      tbl[i].valid    = 4'hF;
      tbl[i].data     = {4'h0, 4'h1, 4'h1, 4'h0};
      tbl[i].ordy     = 1'b1;
      tbl[i].exp_rdy  = 4'(1 << ch);
      tbl[i].exp_sel  = 2'(ch);
      tbl[i].exp_data = W'((ch == 1) || (ch == 2));
    end

    // Ready must stay low during reset even with valid inputs.
    in_valid  = 4'hF;
    out_ready = 1'b1;
    do_reset();

    // Reset state with idle inputs.
    in_valid = 4'h0;
    #1;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_out_sel", 32'(out_sel), 32'd0);
    check("idle_out_data", 32'(out_data), 32'd0);
    tick();
    tick();

    // Table: all four valid, sustained one word per cycle.
    for (int i = 0; i < 8; i++) begin
      in_valid  = tbl[i].valid;
      in_data   = tbl[i].data;
      out_ready = tbl[i].ordy;
      #1;
      check("tbl_in_ready", 32'(in_ready), 32'(tbl[i].exp_rdy));
      check("tbl_onehot", 32'($countones(in_ready)), 32'd1);
      tick();
      check("tbl_out_valid", 32'(out_valid), 32'd1);
      check("tbl_out_sel", 32'(out_sel), 32'(tbl[i].exp_sel));
      check("tbl_out_data", 32'(out_data), 32'(tbl[i].exp_data));
    end

    // Backpressure after a load on channel 2.
    in_data   = {4'h9, 4'hA, 4'h5, 4'h3};
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    tick();
    check("bp_load_sel", 32'(out_sel), 32'd2);
    in_valid  = 4'hF;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_out_sel", 32'(out_sel), 32'd2);
      check("bp_out_data", 32'(out_data), 32'hA);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), FIXED ? 32'h1 : 32'h8);
    tick();
    check("bp_release_sel", 32'(out_sel), FIXED ? 32'd0 : 32'd3);
    check("bp_release_data", 32'(out_data), FIXED ? 32'h3 : 32'h9);

    // Pointer wrap: load channel 2 (pointer -> 3), then only channel 1 valid.
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b0010;
    #1;
    check("wrap_in_ready", 32'(in_ready), 32'h2);
    tick();
    check("wrap_out_sel", 32'(out_sel), 32'd1);
    check("wrap_out_data", 32'(out_data), 32'h5);
    in_valid = 4'hF;
    #1;
    check("wrap_next_ptr", 32'(in_ready), FIXED ? 32'h1 : 32'h4);
    tick();

    // Reset while FULL and stalled.
    out_ready = 1'b0;
    tick();
    check("mid_full", 32'(out_valid), 32'd1);
    do_reset();
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    check("rst_restart_rdy", 32'(in_ready), 32'h1);
    tick();
    check("rst_restart_sel", 32'(out_sel), 32'd0);
    #1;
    check("rst_second_rdy", 32'(in_ready), FIXED ? 32'h1 : 32'h2);
    tick();

    // Randomized traffic; producers hold valid/data until accepted.
    do_reset();
    in_valid = '0;
    m_last   = -1;
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!in_valid[k] || (m_last == k)) begin
          in_valid[k]          = ($urandom_range(0, 99) < 60);
          in_data[k*W +: W]    = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      #1;
      check("rnd_onehot", 32'($countones(in_ready) <= 1), 32'd1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_tdm4
